// File: rtl/sdspi_saver.sv
// sdspi_saver: copies a RAM region to consecutive SD sectors via the SD SPI controller APB port (mem RD_ADDR/RE/RDATA/RVALID in, APB master out, sdsbusy in, BUSY/DONE/ERR/w_saver_state status, CSUM only with SDSPI_SAVER_CSUM_EN)
module sdspi_saver #(
  parameter int          BLOCKSIZE = 512,
  parameter logic [15:0] BLOCKADDR = 16'h0200,
  parameter logic [15:0] WRCMDADDR = 16'h0004
) (
  input  logic        clk27mhz,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] sector0,
  input  logic [31:0] maddr0,
  input  logic [31:0] len,
  output logic [31:0] RD_ADDR,
  output logic        RE,
  input  logic [31:0] RDATA,
  input  logic        RVALID,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [15:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr,
  input  logic        sdsbusy,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [7:0]  w_saver_state
`ifdef SDSPI_SAVER_CSUM_EN
  ,
  output logic [31:0] CSUM
`endif
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, MRD = 4'd1, BSETUP = 4'd2, BACC = 4'd3, PAD = 4'd4,
    CSETUP = 4'd5, CACC = 4'd6, WBUSY = 4'd7, WIDLE = 4'd8
  } state_t;
  localparam logic [31:0] MASK = 32'(BLOCKSIZE - 1);
  state_t st, nxt;
  logic [31:0] sector, maddr, ln, off, word;
  logic [1:0] b;
  logic ph;
  logic [31:0] boff, off4;
  logic go, blk_aligned, unused;
`ifdef SDSPI_SAVER_CSUM_EN
  logic [31:0] csum;
  assign CSUM = csum;
`endif
  assign boff = off + {30'd0, b};
  assign off4 = off + 32'd4;
  assign go = start && !sdsbusy;
  assign blk_aligned = (off & MASK) == 32'd0;
  assign unused = ^{prdata, len[1:0]};
  assign BUSY = st != IDLE;
  assign w_saver_state = {4'd0, st};
  assign pwrite = psel;
  always_comb begin
    nxt = st;
    RE = 1'b0;
    RD_ADDR = 32'd0;
    psel = 1'b0;
    penable = 1'b0;
    paddr = 16'd0;
    pwdata = 32'd0;
    case (st)
      IDLE: nxt = (go && len[31:2] != 30'd0) ? MRD : IDLE;
      MRD: begin
        RE = 1'b1;
        RD_ADDR = maddr + off;
        nxt = RVALID ? BSETUP : MRD;
      end
      BSETUP, BACC: begin
        psel = 1'b1;
        penable = st == BACC;
        paddr = BLOCKADDR + 16'(boff & MASK);
        pwdata = {24'h0, word[{b, 3'b000} +: 8]};
        nxt = st == BSETUP ? BACC : !pready ? BACC : pslverr ? IDLE : b != 2'd3 ? BSETUP :
              ((off4 & MASK) == 32'd0 || off4 == ln) ? PAD : MRD;
      end
      // ph=0 is the setup phase of a pad write, ph=1 its access phase; an aligned
      // offset in setup means the block is already full and we move on to the command
      PAD: begin
        psel = ph || !blk_aligned;
        penable = ph;
        paddr = BLOCKADDR + 16'(off & MASK);
        nxt = (!ph && blk_aligned) ? CSETUP : (ph && pready) ? (pslverr ? IDLE : PAD) : PAD;
      end
      CSETUP, CACC: begin
        psel = 1'b1;
        penable = st == CACC;
        paddr = WRCMDADDR;
        pwdata = sector;
        nxt = st == CSETUP ? CACC : !pready ? CACC : pslverr ? IDLE : WBUSY;
      end
      WBUSY: nxt = sdsbusy ? WIDLE : WBUSY;
      WIDLE: nxt = sdsbusy ? WIDLE : off >= ln ? IDLE : MRD;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk27mhz or posedge reset) begin
    if (reset) begin
      st <= IDLE;
      sector <= 32'd0;
      maddr <= 32'd0;
      ln <= 32'd0;
      off <= 32'd0;
      word <= 32'd0;
      b <= 2'd0;
      ph <= 1'b0;
      DONE <= 1'b0;
      ERR <= 1'b0;
`ifdef SDSPI_SAVER_CSUM_EN
      csum <= 32'd0;
`endif
    end else begin
      st <= nxt;
      if (st == IDLE && go) begin
        sector <= sector0;
        maddr <= maddr0;
        ln <= {len[31:2], 2'b00};
        off <= 32'd0;
        ERR <= 1'b0;
        DONE <= len[31:2] == 30'd0;
`ifdef SDSPI_SAVER_CSUM_EN
        csum <= 32'd0;
`endif
      end
      if (st == MRD && RVALID) begin
        word <= RDATA;
        b <= 2'd0;
`ifdef SDSPI_SAVER_CSUM_EN
        csum <= csum + RDATA;
`endif
      end
      if (st == BACC && pready && !pslverr) begin
        b <= b + 2'd1;
        if (b == 2'd3) off <= off4;
      end
      if (st == PAD && (ph || !blk_aligned)) begin
        if (!ph) ph <= 1'b1;
        else if (pready) begin
          ph <= 1'b0;
          if (!pslverr) off <= off + 32'd1;
        end
      end
      if (penable && pready && pslverr) ERR <= 1'b1;
      if (st == WIDLE && !sdsbusy) begin
        sector <= sector + 32'd1;
        if (off >= ln) DONE <= 1'b1;
      end
    end
  end
endmodule
